// File: rtl/phy_tx_arb_vc_if.sv
// Upstream flit stream plus encoder launch bundle for the PHY TX arbiter.
interface phy_tx_arb_vc_if #(
    parameter int FLIT_W = 64
);
    logic              data_valid;
    logic              data_sop;
    logic              data_eop;
    logic [FLIT_W-1:0] data_flit;
    logic              data_ready;
    logic              enc_start;
    logic [2:0]        enc_sel;
    logic [FLIT_W-1:0] enc_flit;
    logic              enc_done;

    modport master (
        output data_valid, data_sop, data_eop, data_flit, enc_done,
        input  data_ready, enc_start, enc_sel, enc_flit
    );

    modport slave (
        input  data_valid, data_sop, data_eop, data_flit, enc_done,
        output data_ready, enc_start, enc_sel, enc_flit
    );
endinterface

// File: rtl/phy_tx_arb_vc.sv
// PHY TX arbiter: interleaves ACK/NACK/credit-grant commas with data flits,
// bounding data bursts while commas wait.
module phy_tx_arb_vc #(
    parameter int NUM_VC    = 2,
    parameter int FLIT_W    = 64,
    parameter int CNT_W     = 4,
    parameter int MAX_BURST = 4
) (
    input  logic              CLK,
    input  logic              nRST,
    input  logic              ack_write,
    input  logic              nack_write,
    input  logic [NUM_VC-1:0] grtcred_write,
    output logic              ack_full,
    output logic              nack_full,
    output logic [NUM_VC-1:0] grtcred_full,
    output logic              ovf_err,
    phy_tx_arb_vc_if.slave    io
);
    localparam int VC_W = (NUM_VC > 1) ? $clog2(NUM_VC) : 1;
    localparam int BW   = $clog2(MAX_BURST + 1);
    localparam logic [CNT_W-1:0] CMAX = '1;
    localparam logic [2:0] SEL_DATA = 3'd0;
    localparam logic [2:0] SEL_SOP  = 3'd1;
    localparam logic [2:0] SEL_EOP  = 3'd2;
    localparam logic [2:0] SEL_ACK  = 3'd3;
    localparam logic [2:0] SEL_NACK = 3'd4;
    localparam logic [2:0] SEL_GRT  = 3'd5;

    typedef enum logic {IDLE, BUSY} state_e;
    typedef enum logic [1:0] {SVC_NONE, SVC_ACK, SVC_NACK, SVC_GRT} svc_e;

    state_e            state_q, state_d;
    svc_e              svc_q, svc_d;
    logic [VC_W-1:0]   svc_vc_q, svc_vc_d;
    logic [VC_W-1:0]   rr_q, rr_d;
    logic [CNT_W-1:0]  ack_q, ack_d, nack_q, nack_d;
    logic [CNT_W-1:0]  grt_q [NUM_VC];
    logic [CNT_W-1:0]  grt_d [NUM_VC];
    logic [BW-1:0]     burst_q, burst_d;
    logic              pkt_q, pkt_d;
    logic              ovf_q, ovf_d;
    logic              start_q, start_d;
    logic [2:0]        sel_q, sel_d;
    logic [FLIT_W-1:0] flit_q, flit_d;

    int                idx;
    logic [VC_W-1:0]   idx_v;
    logic              grt_any;
    logic [VC_W-1:0]   grt_pick;
    logic              ctrl_pend, done, idle, data_first;
    logic              go_data, go_ack, go_nack, go_grt, go_ctrl;

    // Round-robin search starting at rr_q, wrapping around
    always_comb begin
        grt_any  = 1'b0;
        grt_pick = '0;
        idx      = 0;
        idx_v    = '0;
        for (int i = 0; i < NUM_VC; i++) begin
            idx = int'(rr_q) + i;
            if (idx >= NUM_VC) idx = idx - NUM_VC;
            idx_v = VC_W'(idx);
            if (!grt_any && grt_q[idx_v] != '0) begin
                grt_any  = 1'b1;
                grt_pick = idx_v;
            end
        end
    end

    assign ctrl_pend  = (ack_q != '0) || (nack_q != '0) || grt_any;
    assign done       = (state_q == BUSY) && io.enc_done;
    assign idle       = (state_q == IDLE) && nRST;
    assign data_first = pkt_q && (burst_q < BW'(MAX_BURST)) && io.data_valid;

    always_comb begin
        go_data = 1'b0;
        go_ack  = 1'b0;
        go_nack = 1'b0;
        go_grt  = 1'b0;
        if (idle) begin
            if (data_first)          go_data = 1'b1;
            else if (nack_q != '0)   go_nack = 1'b1;
            else if (ack_q != '0)    go_ack  = 1'b1;
            else if (grt_any)        go_grt  = 1'b1;
            else if (io.data_valid)  go_data = 1'b1;
        end
    end

    assign go_ctrl = go_ack || go_nack || go_grt;

    always_comb begin
        state_d  = state_q;
        svc_d    = svc_q;
        svc_vc_d = svc_vc_q;
        rr_d     = rr_q;
        sel_d    = sel_q;
        flit_d   = flit_q;
        start_d  = 1'b0;
        pkt_d    = pkt_q;
        burst_d  = burst_q;
        if (go_data || go_ctrl) begin
            state_d  = BUSY;
            start_d  = 1'b1;
            flit_d   = '0;
            svc_vc_d = '0;
        end
        if (go_nack) begin
            sel_d = SEL_NACK;
            svc_d = SVC_NACK;
        end else if (go_ack) begin
            sel_d = SEL_ACK;
            svc_d = SVC_ACK;
        end else if (go_grt) begin
            sel_d    = SEL_GRT;
            svc_d    = SVC_GRT;
            svc_vc_d = grt_pick;
            flit_d[FLIT_W-1 -: 8] = 8'(grt_pick);
            rr_d = (grt_pick == VC_W'(NUM_VC - 1)) ? '0 : grt_pick + VC_W'(1);
        end else if (go_data) begin
            svc_d  = SVC_NONE;
            flit_d = io.data_flit;
            if (io.data_sop)      sel_d = SEL_SOP;
            else if (io.data_eop) sel_d = SEL_EOP;
            else                  sel_d = SEL_DATA;
            if (io.data_eop)      pkt_d = 1'b0;
            else if (io.data_sop) pkt_d = 1'b1;
        end
        if (done) state_d = IDLE;
        // Burst only counts data sent while a comma is waiting
        if (!ctrl_pend || go_ctrl) burst_d = '0;
        else if (go_data && burst_q < BW'(MAX_BURST)) burst_d = burst_q + BW'(1);
    end

    always_comb begin
        ovf_d  = ovf_q;
        ack_d  = ack_q;
        nack_d = nack_q;
        if (ack_write && !(done && svc_q == SVC_ACK)) begin
            if (ack_q == CMAX) ovf_d = 1'b1;
            else               ack_d = ack_q + CNT_W'(1);
        end else if (!ack_write && done && svc_q == SVC_ACK) begin
            ack_d = ack_q - CNT_W'(1);
        end
        if (nack_write && !(done && svc_q == SVC_NACK)) begin
            if (nack_q == CMAX) ovf_d  = 1'b1;
            else                nack_d = nack_q + CNT_W'(1);
        end else if (!nack_write && done && svc_q == SVC_NACK) begin
            nack_d = nack_q - CNT_W'(1);
        end
        for (int v = 0; v < NUM_VC; v++) begin
            grt_d[v] = grt_q[v];
            if (grtcred_write[v] && !(done && svc_q == SVC_GRT && svc_vc_q == VC_W'(v))) begin
                if (grt_q[v] == CMAX) ovf_d    = 1'b1;
                else                  grt_d[v] = grt_q[v] + CNT_W'(1);
            end else if (!grtcred_write[v] && done && svc_q == SVC_GRT
                         && svc_vc_q == VC_W'(v)) begin
                grt_d[v] = grt_q[v] - CNT_W'(1);
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (!nRST) begin
            state_q  <= IDLE;
            svc_q    <= SVC_NONE;
            svc_vc_q <= '0;
            rr_q     <= '0;
            ack_q    <= '0;
            nack_q   <= '0;
            burst_q  <= '0;
            pkt_q    <= 1'b0;
            ovf_q    <= 1'b0;
            start_q  <= 1'b0;
            sel_q    <= '0;
            flit_q   <= '0;
            for (int v = 0; v < NUM_VC; v++) grt_q[v] <= '0;
        end else begin
            state_q  <= state_d;
            svc_q    <= svc_d;
            svc_vc_q <= svc_vc_d;
            rr_q     <= rr_d;
            ack_q    <= ack_d;
            nack_q   <= nack_d;
            burst_q  <= burst_d;
            pkt_q    <= pkt_d;
            ovf_q    <= ovf_d;
            start_q  <= start_d;
            sel_q    <= sel_d;
            flit_q   <= flit_d;
            for (int v = 0; v < NUM_VC; v++) grt_q[v] <= grt_d[v];
        end
    end

    always_comb begin
        for (int v = 0; v < NUM_VC; v++) grtcred_full[v] = (grt_q[v] == CMAX);
    end

    assign ack_full      = (ack_q == CMAX);
    assign nack_full     = (nack_q == CMAX);
    assign ovf_err       = ovf_q;
    assign io.data_ready = go_data;
    assign io.enc_start  = start_q;
    assign io.enc_sel    = sel_q;
    assign io.enc_flit   = flit_q;
endmodule

// File: tb/tb_phy_tx_arb_vc.sv
// Directed bench for phy_tx_arb_vc: comma ordering, round-robin,
// burst limiting, saturation/overflow and reset abandon.
module tb_phy_tx_arb_vc;
    logic       CLK = 1'b0;
    logic       nRST;
    logic       ack_write, nack_write;
    logic [1:0] grtcred_write;
    logic       ack_full, nack_full, ovf_err;
    logic [1:0] grtcred_full;
    int         checks   = 0;
    int         failures = 0;

    phy_tx_arb_vc_if #(.FLIT_W(64)) bus ();

    phy_tx_arb_vc #(
        .NUM_VC(2), .FLIT_W(64), .CNT_W(2), .MAX_BURST(4)
    ) dut (
        .CLK(CLK), .nRST(nRST),
        .ack_write(ack_write), .nack_write(nack_write),
        .grtcred_write(grtcred_write),
        .ack_full(ack_full), .nack_full(nack_full),
        .grtcred_full(grtcred_full), .ovf_err(ovf_err),
        .io(bus)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        @(negedge CLK);
    endtask

    task automatic finish_enc();
        bus.enc_done = 1'b1;
        step();
        bus.enc_done = 1'b0;
    endtask

    function automatic logic [63:0] dflit(input int k);
        return 64'hF00D_0000_0000_0000 | 64'(k);
    endfunction

    logic [2:0] exp_sel [11] = '{3'd1, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0,
                                 3'd0, 3'd3, 3'd0, 3'd0, 3'd2};
    int k;

    initial begin
        nRST = 1'b0;
        ack_write = 1'b0;
        nack_write = 1'b0;
        grtcred_write = 2'b00;
        bus.data_valid = 1'b1;
        bus.data_sop = 1'b0;
        bus.data_eop = 1'b0;
        bus.data_flit = '0;
        bus.enc_done = 1'b0;
        @(negedge CLK);
        step();
        #1;
        chk("rst_ready", 64'(bus.data_ready), 64'd0);
        chk("rst_start", 64'(bus.enc_start), 64'd0);
        chk("rst_sel", 64'(bus.enc_sel), 64'd0);
        chk("rst_flit", bus.enc_flit, 64'd0);
        chk("rst_ovf", 64'(ovf_err), 64'd0);
        chk("rst_full", 64'({ack_full, nack_full, grtcred_full}), 64'd0);
        bus.data_valid = 1'b0;
        nRST = 1'b1;
        step();

        // single ACK
        ack_write = 1'b1;
        step();
        ack_write = 1'b0;
        chk("ack_decide_start", 64'(bus.enc_start), 64'd0);
        step();
        chk("ack_start", 64'(bus.enc_start), 64'd1);
        chk("ack_sel", 64'(bus.enc_sel), 64'd3);
        chk("ack_flit", bus.enc_flit, 64'd0);
        step();
        chk("ack_start_once", 64'(bus.enc_start), 64'd0);
        finish_enc();
        step();
        chk("ack_cnt_zero", 64'(dut.ack_q), 64'd0);
        chk("ack_no_relaunch", 64'(bus.enc_start), 64'd0);

        // NACK before ACK
        nack_write = 1'b1;
        ack_write = 1'b1;
        step();
        nack_write = 1'b0;
        ack_write = 1'b0;
        step();
        chk("nack_first_start", 64'(bus.enc_start), 64'd1);
        chk("nack_first_sel", 64'(bus.enc_sel), 64'd4);
        finish_enc();
        step();
        chk("ack_second_start", 64'(bus.enc_start), 64'd1);
        chk("ack_second_sel", 64'(bus.enc_sel), 64'd3);
        finish_enc();
        step();
        chk("na_idle", 64'(bus.enc_start), 64'd0);

        // credit grants, both VCs
        grtcred_write = 2'b11;
        step();
        grtcred_write = 2'b00;
        step();
        chk("grt0_sel", 64'(bus.enc_sel), 64'd5);
        chk("grt0_vc", 64'(bus.enc_flit[63:56]), 64'd0);
        chk("grt0_low", 64'(bus.enc_flit[55:0]), 64'd0);
        finish_enc();
        step();
        chk("grt1_start", 64'(bus.enc_start), 64'd1);
        chk("grt1_sel", 64'(bus.enc_sel), 64'd5);
        chk("grt1_vc", 64'(bus.enc_flit[63:56]), 64'd1);
        finish_enc();
        chk("grt_rr_end", 64'(dut.rr_q), 64'd0);

        // 10-flit packet, ACK requested during flit 2
        k = 0;
        for (int i = 0; i < 11; i++) begin
            bus.data_valid = 1'b1;
            bus.data_sop = (k == 0);
            bus.data_eop = (k == 9);
            bus.data_flit = dflit(k);
            ack_write = (i == 2);
            #1;
            chk($sformatf("pkt_ready_%0d", i), 64'(bus.data_ready), (i == 7) ? 64'd0 : 64'd1);
            step();
            ack_write = 1'b0;
            chk($sformatf("pkt_start_%0d", i), 64'(bus.enc_start), 64'd1);
            chk($sformatf("pkt_sel_%0d", i), 64'(bus.enc_sel), 64'(exp_sel[i]));
            chk($sformatf("pkt_flit_%0d", i), bus.enc_flit, (i == 7) ? 64'd0 : dflit(k));
            chk($sformatf("pkt_busy_ready_%0d", i), 64'(bus.data_ready), 64'd0);
            if (i != 7) k++;
            finish_enc();
        end
        bus.data_valid = 1'b0;
        bus.data_sop = 1'b0;
        bus.data_eop = 1'b0;
        chk("pkt_flag_clear", 64'(dut.pkt_q), 64'd0);
        step();

        // saturation with the encoder stalled
        ack_write = 1'b1;
        step();
        chk("sat1_full", 64'(ack_full), 64'd0);
        step();
        chk("sat2_full", 64'(ack_full), 64'd0);
        chk("sat2_start", 64'(bus.enc_start), 64'd1);
        step();
        chk("sat3_full", 64'(ack_full), 64'd1);
        chk("sat3_ovf", 64'(ovf_err), 64'd0);
        step();
        ack_write = 1'b0;
        chk("sat4_full", 64'(ack_full), 64'd1);
        chk("sat4_ovf", 64'(ovf_err), 64'd1);
        chk("sat4_busy", 64'(dut.state_q), 64'd1);
        chk("sat4_sel", 64'(bus.enc_sel), 64'd3);

        // reset while busy
        nRST = 1'b0;
        bus.data_valid = 1'b1;
        step();
        #1;
        chk("rb_start", 64'(bus.enc_start), 64'd0);
        chk("rb_sel", 64'(bus.enc_sel), 64'd0);
        chk("rb_flit", bus.enc_flit, 64'd0);
        chk("rb_ready", 64'(bus.data_ready), 64'd0);
        chk("rb_ovf", 64'(ovf_err), 64'd0);
        chk("rb_full", 64'(ack_full), 64'd0);
        chk("rb_cnt", 64'(dut.ack_q), 64'd0);
        chk("rb_state", 64'(dut.state_q), 64'd0);
        bus.data_valid = 1'b0;
        nRST = 1'b1;
        step();
        step();
        chk("post_rst_idle", 64'(bus.enc_start), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/phy_tx_arb_vc.md
PHY_TX_ARB_VC -- requirements
Module: phy_tx_arb_vc

Interface
REQ-001 SHALL have parameter NUM_VC, default 2, number of credit-grant virtual channels (1..8).
REQ-002 SHALL have parameter FLIT_W, default 64, flit width in bits.
REQ-003 SHALL have parameter CNT_W, default 4, width of each pending-comma counter.
REQ-004 SHALL have parameter MAX_BURST, default 4, maximum consecutive data flits sent while any control comma is pending.
REQ-005 CLK  in  1  sole clock, rising edge.
REQ-006 nRST  in  1  reset; one clock; reset is synchronous and active-low.
REQ-007 ack_write  in  1  one-cycle request to queue one ACK comma.
REQ-008 nack_write  in  1  one-cycle request to queue one NACK comma.
REQ-009 grtcred_write  in  NUM_VC  per-VC request to queue one credit-grant comma.
REQ-010 data_valid  in  1  upstream flit available.
REQ-011 data_sop / data_eop  in  1 each  flit starts / ends a packet.
REQ-012 data_flit  in  FLIT_W  flit payload.
REQ-013 data_ready  out  1  flit accepted this cycle.
REQ-014 enc_start  out  1  one-cycle launch to encoder.
REQ-015 enc_sel  out  3  0 DATA, 1 START_PACKET, 2 END_PACKET, 3 ACK, 4 NACK, 5 GRTCRED.
REQ-016 enc_flit  out  FLIT_W  flit sent to encoder, held stable while busy.
REQ-017 enc_done  in  1  encoder finished current flit.
REQ-018 ack_full, nack_full  out  1 each  counter at maximum.
REQ-019 grtcred_full  out  NUM_VC  per-VC counter at maximum.
REQ-020 ovf_err  out  1  sticky: a write arrived on a full counter.

Function
REQ-021 SHALL keep saturating counters ack_cnt, nack_cnt, grt_cnt[v], each CNT_W wide; *_full = (count == 2^CNT_W-1), combinational.
REQ-022 Write with no same-cycle decrement SHALL increment; write with decrement SHALL leave count unchanged; write on full counter without decrement SHALL be dropped and set ovf_err.
REQ-023 FSM states: IDLE, BUSY. IDLE->BUSY on launch; BUSY->IDLE on enc_done.
REQ-024 In IDLE, priority for launch: NACK > ACK > GRTCRED > data, except data wins over all control when burst_cnt < MAX_BURST and a packet is in progress (after SOP, before EOP).
REQ-025 GRTCRED SHALL pick first VC with nonzero count at or after rr_ptr (wrapping); after that launch rr_ptr = chosen+1 mod NUM_VC.
REQ-026 Launch SHALL register enc_sel/enc_flit and drive enc_start=1 the cycle after the decision; enc_start SHALL be high exactly one cycle per flit.
REQ-027 Data launch: data_ready=1 in the decision cycle (data_valid=1 required); enc_sel = START_PACKET if sop, else END_PACKET if eop, else DATA; enc_flit = data_flit.
REQ-028 Control launch: enc_flit[FLIT_W-1:FLIT_W-8] = VC index (GRTCRED) or 0; remaining bits 0.
REQ-029 Serviced counter SHALL decrement on the enc_done cycle.
REQ-030 burst_cnt SHALL increment per data launch while any control count is nonzero, saturate at MAX_BURST, clear on any control launch or when no control is pending.
REQ-031 data_ready SHALL never assert in BUSY; at most one launch per IDLE visit; enc_done in IDLE SHALL be ignored.
REQ-032 Packet-in-progress flag SHALL set on SOP launch without EOP, clear on EOP launch.

Reset
REQ-033 While nRST=0 at a rising edge: counters, burst_cnt, rr_ptr, packet flag, ovf_err = 0; state IDLE; enc_start=0, enc_sel=0, enc_flit=0, data_ready=0.
REQ-034 Reset mid-BUSY SHALL abandon the flit with no decrement; pending commas are lost.

Verification
REQ-035 ack_write one cycle in IDLE -> enc_start 1 cycle later, enc_sel=3, enc_flit=0; enc_done -> ack_cnt 0.
REQ-036 nack_write and ack_write same cycle -> NACK (4) launched first, then ACK (3).
REQ-037 NUM_VC=2, grtcred_write=2'b11 -> GRTCRED for VC0 then VC1 (enc_flit top byte 0 then 1); rr_ptr ends 0.
REQ-038 Packet of 10 flits streaming, ack_write at flit 2 -> ACK inserted after 4 data flits (MAX_BURST=4).
REQ-039 CNT_W=2, four ack_write with encoder stalled -> ack_full=1 after third, fourth dropped, ovf_err=1.
REQ-040 nRST low during BUSY -> next cycle all outputs 0, state IDLE, counters 0.
